spi_shifter: RTL and testbench
==============================

Name: spi_shifter

Overview:
SPI master shift engine that sits directly downstream of the peripherals register block. Peripherals supplies the TX word, the width select and a start level. The engine returns the busy status and the RX word. It drives sclk/mosi and samples miso in SPI mode 0 (CPOL=0, CPHA=0), MSB first, with 8- or 16-bit frames. All logic runs on raw_clk, and sclk is derived from it by a programmable divider.

Parameters:
DIVISOR, 4, sclk half-period in raw_clk cycles; legal range 1..255.

Ports:
raw_clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  transfer request level; held by the producer until busy is seen.
width_16  input  1  frame width: 1 = 16 bits, 0 = 8 bits; sampled at start acceptance.
data_tx  input  16  TX word; 8-bit frames send data_tx[7:0]; sampled at start acceptance.
data_rx  output  16  last received frame, zero-extended for 8-bit frames.
busy  output  1  high from the cycle after acceptance until the frame completes.
done  output  1  one-cycle pulse when data_rx is updated.
sclk  output  1  SPI clock; idles low.
mosi  output  1  SPI data out.
miso  input  1  SPI data in.

Behaviour:
- Reset (async, any state) sets every output and internal register to 0:
  - outputs: data_rx, busy, done, sclk, mosi;
  - internal: tx/rx shift registers, bit counter, divider counter, armed flag;
  - state goes to IDLE.
- States:
  - IDLE: waiting for an accepted start.
  - SHIFT_LOW: sclk=0; mosi holds the current bit.
  - SHIFT_HIGH: sclk=1.
  - DONE: returns to IDLE on the next cycle.
- Armed flag:
  - Set in IDLE whenever start=0.
  - Cleared on acceptance.
  - Effect: a start held continuously across the end of a frame never launches a second frame; start must be seen low for at least one cycle first.
- Acceptance:
  - Condition: IDLE && start && armed.
  - On that cycle (cycle 0) the block latches width_16 and data_tx.
  - Bit count N = 16 or 8.
  - TX shift register is loaded left-aligned, so its MSB is data_tx[15] or data_tx[7].
- Cycle 1:
  - State is SHIFT_LOW, busy=1, mosi = first bit, divider counter = 0, sclk=0.
- Divider:
  - Counts raw_clk cycles in each SHIFT state.
  - On reaching DIVISOR-1 it resets to 0 and the state toggles.
- SHIFT_LOW -> SHIFT_HIGH:
  - sclk goes 1 on the same edge.
  - miso is sampled on that edge into the LSB of the RX shift register (shift left).
- SHIFT_HIGH -> SHIFT_LOW:
  - sclk goes 0.
  - The TX register shifts left and mosi presents the next bit.
  - The bit counter decrements.
  - If this was the Nth falling edge, the state goes to DONE instead.
- Entry to DONE:
  - Occurs at cycle 1+2*DIVISOR*N.
  - On that edge: sclk=0, busy=0, done=1.
  - data_rx = RX shift register, zero-extended to 16 bits.
  - mosi returns to 0.
- DONE -> IDLE on the following cycle; done returns to 0.
- Changes to data_tx, width_16 or start while busy are ignored.
- data_rx holds its value until the next DONE or reset.
- Mode 0 timing: mosi is always stable for DIVISOR cycles before each rising sclk edge.
- Boundary cases:
  - DIVISOR=1: sclk = raw_clk/2; the N=8 frame completes at cycle 17.
  - Reset mid-frame: sclk and mosi drop immediately, no done pulse, data_rx=0.
  - start rising in the same cycle as DONE: not accepted; acceptance is earliest at the IDLE cycle with armed=1.

Test Plan:
1. DIVISOR=4, width_16=0, data_tx=0x00A5, miso looped to mosi, start pulsed 1 cycle -> busy=1 at cycle 1; 8 sclk rising edges; mosi sequence 1,0,1,0,0,1,0,1; busy=0 and done=1 at cycle 65; data_rx=0x00A5.
2. DIVISOR=4, width_16=1, data_tx=0xBEEF, slave model driving 0x1234 MSB-first on falling edges -> 16 sclk pulses; mosi sequence matches 0xBEEF; data_rx=0x1234 at cycle 129.
3. start held high through the end of frame 1 -> exactly one done pulse and busy stays 0; start low for 1 cycle then high -> second frame begins one cycle later.
4. data_tx changed to 0xFFFF and width_16 toggled at cycle 10 of an 8-bit 0x003C frame -> mosi still shows 0x3C bits; frame is 8 bits long.
5. Async reset asserted at cycle 30 of a frame (between clock edges) -> sclk, mosi, busy drop immediately; no done pulse; data_rx=0; a new start after reset release is accepted.
6. DIVISOR=1, 8-bit frame, miso tied to 1 -> sclk toggles every cycle; done at cycle 17; data_rx=0x00FF.

Source files
------------

// File: rtl/spi_shifter.sv
// SPI mode-0 master shift engine, 8/16-bit frames, MSB first.
// sclk is a divided copy of raw_clk; all state runs on raw_clk.
module spi_shifter #(
  parameter int DIVISOR = 4
) (
  input  logic        raw_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        width_16,
  input  logic [15:0] data_tx,
  output logic [15:0] data_rx,
  output logic        busy,
  output logic        done,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  localparam logic [7:0] DIV_LAST = 8'(DIVISOR - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LOW,
    SHIFT_HIGH,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] tx_sr;
  logic [15:0] rx_sr;
  logic [4:0]  bit_cnt;
  logic [7:0]  div_cnt;
  logic        armed;
  logic        wide;
  logic        tick;
  logic        accept;
  logic        last;

  // mosi is the MSB of the left-aligned TX register
  assign mosi = tx_sr[15];

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    tick       = (div_cnt == DIV_LAST);
    accept     = (state == IDLE) && start && armed;
    last       = (bit_cnt == 5'd1);
    unique case (state)
      IDLE:       if (accept) state_next = SHIFT_LOW;
      SHIFT_LOW:  if (tick) state_next = SHIFT_HIGH;
      SHIFT_HIGH: if (tick) state_next = last ? DONE : SHIFT_LOW;
      DONE:       state_next = IDLE;
    endcase
  end

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      armed   <= 1'b0;
      wide    <= 1'b0;
      data_rx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!start) armed <= 1'b1;
          if (accept) begin
            armed   <= 1'b0;
            busy    <= 1'b1;
            wide    <= width_16;
            tx_sr   <= width_16 ? data_tx : {data_tx[7:0], 8'h00};
            rx_sr   <= '0;
            bit_cnt <= width_16 ? 5'd16 : 5'd8;
            div_cnt <= '0;
            sclk    <= 1'b0;
          end
        end
        SHIFT_LOW: begin
          if (tick) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            rx_sr   <= {rx_sr[14:0], miso};
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        SHIFT_HIGH: begin
          if (tick) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt - 5'd1;
            if (last) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              tx_sr   <= '0;
              data_rx <= wide ? rx_sr : {8'h00, rx_sr[7:0]};
            end else begin
              tx_sr <= {tx_sr[14:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shifter.sv
// Scoreboard bench for spi_shifter: DIVISOR=4 instance for the
// main scenarios, DIVISOR=1 instance for the fast-clock corner.
module tb_spi_shifter;

  logic        raw_clk = 1'b0;
  logic        reset;
  logic        start, width_16, slave_mode;
  logic [15:0] data_tx, data_rx, slave_sr;
  logic        busy, done, sclk, mosi;
  wire         miso = slave_mode ? slave_sr[15] : mosi;

  logic        start1, width1;
  logic [15:0] data1, data_rx1;
  logic        busy1, done1, sclk1, mosi1;
  logic        miso1;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit track = 1'b1;
  logic sclk_q = 1'b0;

  logic [15:0] exp_rx[$];
  int          exp_cyc[$];
  logic        exp_bits[$];

  spi_shifter #(.DIVISOR(4)) u_dut (
    .raw_clk(raw_clk), .reset(reset), .start(start),
    .width_16(width_16), .data_tx(data_tx), .data_rx(data_rx),
    .busy(busy), .done(done), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  spi_shifter #(.DIVISOR(1)) u_dut1 (
    .raw_clk(raw_clk), .reset(reset), .start(start1),
    .width_16(width1), .data_tx(data1), .data_rx(data_rx1),
    .busy(busy1), .done(done1), .sclk(sclk1), .mosi(mosi1), .miso(miso1)
  );

  always #5 raw_clk = ~raw_clk;
  always @(posedge raw_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Monitor: mosi on rising sclk, slave shift on falling, scoreboard on done
  always @(negedge raw_clk) begin
    if (sclk && !sclk_q && track) begin
      if (exp_bits.size() == 0) check("extra_bit", 1, 0);
      else check("mosi_bit", mosi, exp_bits.pop_front());
    end
    if (!sclk && sclk_q) slave_sr = {slave_sr[14:0], 1'b0};
    if (done) begin
      done_cnt++;
      if (!track || exp_rx.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        check("data_rx", data_rx, exp_rx.pop_front());
        check("done_cycle", cyc, exp_cyc.pop_front());
        check("bits_left", exp_bits.size(), 0);
        check("busy_at_done", busy, 0);
      end
    end
    sclk_q = sclk;
  end

  // Called at a negedge with start low beforehand; returns at cycle 1
  task automatic start_frame(input logic w16, input logic [15:0] d,
                             input logic [15:0] rx, input bit hold);
    int n;
    n = w16 ? 16 : 8;
    width_16 = w16;
    data_tx  = d;
    start    = 1'b1;
    if (track) begin
      for (int i = n - 1; i >= 0; i--) exp_bits.push_back(d[i]);
      exp_rx.push_back(rx);
      exp_cyc.push_back(cyc + 1 + 2 * 4 * n);
    end
    @(negedge raw_clk);
    check("busy_c1", busy, 1);
    check("sclk_c1", sclk, 0);
    check("mosi_c1", mosi, w16 ? d[15] : d[7]);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge raw_clk);
      k++;
    end
    if (busy) check("timeout", 1, 0);
    repeat (2) @(negedge raw_clk);
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 0; width_16 = 0; data_tx = 0;
    slave_mode = 0; slave_sr = 0;
    start1 = 0; width1 = 0; data1 = 0; miso1 = 1'b1;
    repeat (2) @(negedge raw_clk);
    check("rst_data_rx", data_rx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy1", busy1, 0);
    reset = 1'b0;
    repeat (2) @(negedge raw_clk);

    // 1: 8-bit loopback
    start_frame(1'b0, 16'h00A5, 16'h00A5, 1'b0);
    wait_done(200);

    // 2: 16-bit against slave sending 0x1234
    slave_mode = 1'b1;
    slave_sr   = 16'h1234;
    start_frame(1'b1, 16'hBEEF, 16'h1234, 1'b0);
    wait_done(300);
    slave_mode = 1'b0;

    // 3: start held across frame end, then re-armed
    d0 = done_cnt;
    start_frame(1'b0, 16'h005A, 16'h005A, 1'b1);
    wait_done(200);
    repeat (4) @(negedge raw_clk);
    check("held_busy", busy, 0);
    check("held_done_cnt", done_cnt - d0, 1);
    start = 1'b0;
    @(negedge raw_clk);
    start_frame(1'b0, 16'h00C3, 16'h00C3, 1'b0);
    wait_done(200);

    // 4: inputs changed mid-frame are ignored
    start_frame(1'b0, 16'h003C, 16'h003C, 1'b0);
    repeat (9) @(negedge raw_clk);
    data_tx  = 16'hFFFF;
    width_16 = 1'b1;
    start    = 1'b1;
    @(negedge raw_clk);
    start = 1'b0;
    wait_done(200);
    width_16 = 1'b0;

    // 5: async reset mid-frame
    track = 1'b0;
    d0 = done_cnt;
    start_frame(1'b0, 16'h00FF, 16'h0000, 1'b0);
    repeat (29) @(negedge raw_clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_sclk", sclk, 0);
    check("rst_mid_mosi", mosi, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_data_rx", data_rx, 0);
    @(negedge raw_clk);
    reset = 1'b0;
    repeat (3) @(negedge raw_clk);
    check("rst_mid_no_done", done_cnt - d0, 0);
    track = 1'b1;
    start_frame(1'b0, 16'h0081, 16'h0081, 1'b0);
    wait_done(200);

    // 6: DIVISOR=1, miso tied high
    data1  = 16'h0055;
    start1 = 1'b1;
    @(negedge raw_clk);
    check("d1_busy_c1", busy1, 1);
    start1 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      check("d1_sclk", sclk1, (k % 2) == 0);
      @(negedge raw_clk);
    end
    check("d1_done", done1, 1);
    check("d1_busy", busy1, 0);
    check("d1_data_rx", data_rx1, 16'h00FF);
    @(negedge raw_clk);
    check("d1_done_clr", done1, 0);

    check("rx_queue_empty", exp_rx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
